pulse_generator: RTL and testbench

Converts single-cycle trigger events back into level pulses of programmable width and polarity, separated by a programmable minimum gap; triggers arriving while a pulse or gap is in progress are queued by a saturating counter. It is the complement of the edge detector in lib/signal: an edge detector downstream of this block recovers exactly one edge per accepted trigger. It sits in lib/signal and drives strobes, enables and external control lines from event pulses.

---
 rtl/pulse_generator_pkg.sv | 22 ++
 rtl/pulse_generator_sat_updown_counter.sv | 55 +++++
 rtl/pulse_generator.sv | 147 ++++++++++++++
 tb/tb_pulse_generator.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_generator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_generator_pkg
//  Description : Shared state codes and the idle-level helper for the
//                trigger-to-pulse converter.
//  Revision    : 1.0 - initial release
// ============================================================================
package pulse_generator_pkg;

    localparam int unsigned c_STATE_BITS = 2;

    localparam logic [c_STATE_BITS-1:0] c_ST_IDLE   = 2'd0;
    localparam logic [c_STATE_BITS-1:0] c_ST_ACTIVE = 2'd1;
    localparam logic [c_STATE_BITS-1:0] c_ST_GAP    = 2'd2;

    // Output level while no pulse is being driven.
    function automatic logic inactive_level(input bit active_high);
        return ~active_high;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_generator_sat_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_updown_counter
//  Description : Saturating up/down counter holding the number of queued
//                triggers. Simultaneous inc and dec cancel out; an inc at
//                the maximum is dropped and flagged for one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_updown_counter #(
    parameter int p_BITS = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_inc,
    input  logic              i_dec,
    output logic [p_BITS-1:0] o_count,
    output logic              o_overflow
);

    localparam logic [p_BITS-1:0] c_MAX = '1;
    localparam logic [p_BITS-1:0] c_ONE = p_BITS'(1);

    logic [p_BITS-1:0] r_count;
    logic              r_overflow;
    logic              w_up;
    logic              w_down;
    logic              w_drop;

    // Decode net direction; a lone inc at the maximum becomes a drop.
    always_comb begin
        w_up   = i_inc & ~i_dec & (r_count != c_MAX);
        w_down = i_dec & ~i_inc & (r_count != '0);
        w_drop = i_inc & ~i_dec & (r_count == c_MAX);
    end

    // Count register and registered overflow strobe.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_drop;
            if (w_up) begin
                r_count <= r_count + c_ONE;
            end else if (w_down) begin
                r_count <= r_count - c_ONE;
            end
        end
    end

    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/pulse_generator.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_generator
//  Description : Turns single-cycle trigger events into level pulses of
//                programmable width and polarity, separated by a minimum
//                gap. Triggers arriving while busy are queued.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_generator #(
    parameter int p_WIDTH_BITS  = 8,
    parameter int p_QUEUE_BITS  = 2,
    parameter int p_ACTIVE_HIGH = 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_trigger,
    input  logic [p_WIDTH_BITS-1:0] i_width,
    input  logic [p_WIDTH_BITS-1:0] i_gap,
    output logic                    o_pulse,
    output logic                    o_busy,
    output logic [p_QUEUE_BITS-1:0] o_pending,
    output logic                    o_overflow
);

    import pulse_generator_pkg::*;

    localparam logic                    c_IDLE_LEVEL = inactive_level(p_ACTIVE_HIGH != 0);
    localparam logic [p_WIDTH_BITS-1:0] c_TIMER_ONE  = p_WIDTH_BITS'(1);

    logic [c_STATE_BITS-1:0] r_state;
    logic [c_STATE_BITS-1:0] w_state_next;
    logic [p_WIDTH_BITS-1:0] r_timer;
    logic [p_WIDTH_BITS-1:0] w_timer_next;
    logic [p_WIDTH_BITS-1:0] r_gap_len;
    logic [p_WIDTH_BITS-1:0] w_gap_len_next;
    logic [p_WIDTH_BITS-1:0] w_width_load;
    logic [p_WIDTH_BITS-1:0] w_gap_load;
    logic [p_QUEUE_BITS-1:0] w_pending;
    logic                    r_pulse;
    logic                    w_pulse_next;
    logic                    r_busy;
    logic                    w_busy_next;
    logic                    w_inc;
    logic                    w_dec;
    logic                    w_start;
    logic                    w_timer_done;

    // Timer reload values are length minus one; a programmed 0 acts as 1.
    always_comb begin
        w_width_load = (i_width == '0) ? '0 : (i_width - c_TIMER_ONE);
        w_gap_load   = (i_gap   == '0) ? '0 : (i_gap   - c_TIMER_ONE);
        w_timer_done = (r_timer == '0);
    end

    // Next-state, shared timer and queue control for IDLE/ACTIVE/GAP.
    always_comb begin
        w_state_next   = r_state;
        w_timer_next   = r_timer;
        w_gap_len_next = r_gap_len;
        w_pulse_next   = r_pulse;
        w_busy_next    = r_busy;
        w_inc          = 1'b0;
        w_dec          = 1'b0;
        w_start        = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                w_start = i_trigger;
            end
            c_ST_ACTIVE: begin
                w_inc = i_trigger;
                if (w_timer_done) begin
                    w_state_next = c_ST_GAP;
                    w_timer_next = r_gap_len;
                    w_pulse_next = c_IDLE_LEVEL;
                end else begin
                    w_timer_next = r_timer - c_TIMER_ONE;
                end
            end
            c_ST_GAP: begin
                if (!w_timer_done) begin
                    w_inc        = i_trigger;
                    w_timer_next = r_timer - c_TIMER_ONE;
                end else if (w_pending != '0) begin
                    // Serve the queue; a concurrent trigger takes the freed slot.
                    w_dec   = 1'b1;
                    w_inc   = i_trigger;
                    w_start = 1'b1;
                end else if (i_trigger) begin
                    w_start = 1'b1;
                end else begin
                    w_state_next = c_ST_IDLE;
                    w_busy_next  = 1'b0;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
                w_timer_next = '0;
                w_pulse_next = c_IDLE_LEVEL;
                w_busy_next  = 1'b0;
            end
        endcase

        // Starting a pulse samples fresh width/gap settings.
        if (w_start) begin
            w_state_next   = c_ST_ACTIVE;
            w_timer_next   = w_width_load;
            w_gap_len_next = w_gap_load;
            w_pulse_next   = ~c_IDLE_LEVEL;
            w_busy_next    = 1'b1;
        end
    end

    // State, timer and registered outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= c_ST_IDLE;
            r_timer   <= '0;
            r_gap_len <= '0;
            r_pulse   <= c_IDLE_LEVEL;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
            r_gap_len <= w_gap_len_next;
            r_pulse   <= w_pulse_next;
            r_busy    <= w_busy_next;
        end
    end

    sat_updown_counter #(
        .p_BITS (p_QUEUE_BITS)
    ) u_pending (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_inc      (w_inc),
        .i_dec      (w_dec),
        .o_count    (w_pending),
        .o_overflow (o_overflow)
    );

    assign o_pulse   = r_pulse;
    assign o_busy    = r_busy;
    assign o_pending = w_pending;

endmodule
`default_nettype wire

// File: tb/tb_pulse_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_generator
//  Description : Bench for pulse_generator; active-high and active-low
//                instances share one stimulus and one schedule-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_generator;

    localparam int c_WB   = 8;
    localparam int c_QB   = 2;
    localparam int c_MAXQ = (1 << c_QB) - 1;

    logic            clk     = 1'b0;
    logic            rst     = 1'b1;
    logic            trigger = 1'b0;
    logic [c_WB-1:0] width   = '0;
    logic [c_WB-1:0] gap     = '0;

    logic            hi_pulse, hi_busy, hi_ovf;
    logic [c_QB-1:0] hi_pend;
    logic            lo_pulse, lo_busy, lo_ovf;
    logic [c_QB-1:0] lo_pend;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pulse_generator #(.p_WIDTH_BITS(c_WB), .p_QUEUE_BITS(c_QB), .p_ACTIVE_HIGH(1)) u_dut_hi (
        .i_clk(clk), .i_reset(rst), .i_trigger(trigger), .i_width(width), .i_gap(gap),
        .o_pulse(hi_pulse), .o_busy(hi_busy), .o_pending(hi_pend), .o_overflow(hi_ovf)
    );

    pulse_generator #(.p_WIDTH_BITS(c_WB), .p_QUEUE_BITS(c_QB), .p_ACTIVE_HIGH(0)) u_dut_lo (
        .i_clk(clk), .i_reset(rst), .i_trigger(trigger), .i_width(width), .i_gap(gap),
        .o_pulse(lo_pulse), .o_busy(lo_busy), .o_pending(lo_pend), .o_overflow(lo_ovf)
    );

    function automatic void check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Model: each pulse is a schedule (start cycle s, W, G); active in
    // cycles s+1..s+W, last gap cycle is s+W+G.
    int   cyc     = 0;
    int   m_s     = 0;
    int   m_w     = 1;
    int   m_g     = 1;
    int   m_pend  = 0;
    bit   m_busy  = 1'b0;
    bit   m_ovf   = 1'b0;
    bit   m_pulse = 1'b0;

    always @(posedge clk or posedge rst) begin
        bit start;
        if (rst) begin
            m_busy = 1'b0;
            m_pend = 0;
            m_ovf  = 1'b0;
        end else begin
            start = 1'b0;
            m_ovf = 1'b0;
            if (!m_busy) begin
                start = trigger;
            end else if (cyc == m_s + m_w + m_g) begin
                if (m_pend > 0) begin
                    m_pend = m_pend - 1 + (trigger ? 1 : 0);
                    start  = 1'b1;
                end else if (trigger) begin
                    start = 1'b1;
                end else begin
                    m_busy = 1'b0;
                end
            end else if (trigger) begin
                if (m_pend == c_MAXQ) m_ovf = 1'b1;
                else m_pend = m_pend + 1;
            end
            if (start) begin
                m_busy = 1'b1;
                m_s    = cyc;
                m_w    = (width == 0) ? 1 : int'(width);
                m_g    = (gap == 0) ? 1 : int'(gap);
            end
            cyc++;
        end
        m_pulse = m_busy && (cyc >= m_s + 1) && (cyc <= m_s + m_w);
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        check("pulse_hi", int'(hi_pulse), int'(m_pulse));
        check("pulse_lo", int'(lo_pulse), int'(!m_pulse));
        check("busy_hi",  int'(hi_busy),  int'(m_busy));
        check("busy_lo",  int'(lo_busy),  int'(m_busy));
        check("pend_hi",  int'(hi_pend),  m_pend);
        check("pend_lo",  int'(lo_pend),  m_pend);
        check("ovf_hi",   int'(hi_ovf),   int'(m_ovf));
        check("ovf_lo",   int'(lo_ovf),   int'(m_ovf));
    end

    int n_rise = 0;
    int n_fall = 0;
    int n_act  = 0;
    bit prev_hi = 1'b0;
    bit prev_lo = 1'b1;

    task automatic tick(input logic trig);
        @(negedge clk);
        if (hi_pulse && !prev_hi) n_rise++;
        if (!lo_pulse && prev_lo) n_fall++;
        if (hi_pulse) n_act++;
        prev_hi = hi_pulse;
        prev_lo = lo_pulse;
        trigger = trig;
    endtask

    task automatic step(input logic trig, input int ep, input int eb, input int epend,
                        input int eo, input string nm);
        tick(trig);
        check({nm, "_pulse"}, int'(hi_pulse), ep);
        check({nm, "_busy"},  int'(hi_busy),  eb);
        check({nm, "_pend"},  int'(hi_pend),  epend);
        check({nm, "_ovf"},   int'(hi_ovf),   eo);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_pulse_lo", int'(lo_pulse), 1);
        drain(2);

        // Single trigger, W=3 G=2.
        width = 8'd3; gap = 8'd2;
        step(1, 0, 0, 0, 0, "s1_c0");
        step(0, 1, 1, 0, 0, "s1_c1");
        step(0, 1, 1, 0, 0, "s1_c2");
        step(0, 1, 1, 0, 0, "s1_c3");
        step(0, 0, 1, 0, 0, "s1_c4");
        step(0, 0, 1, 0, 0, "s1_c5");
        step(0, 0, 0, 0, 0, "s1_c6");
        drain(3);

        // Three back-to-back triggers, W=2 G=1.
        width = 8'd2; gap = 8'd1;
        step(1, 0, 0, 0, 0, "s2_c0");
        step(1, 1, 1, 0, 0, "s2_c1");
        step(1, 1, 1, 1, 0, "s2_c2");
        step(0, 0, 1, 2, 0, "s2_c3");
        step(0, 1, 1, 1, 0, "s2_c4");
        step(0, 1, 1, 1, 0, "s2_c5");
        step(0, 0, 1, 1, 0, "s2_c6");
        step(0, 1, 1, 0, 0, "s2_c7");
        step(0, 1, 1, 0, 0, "s2_c8");
        step(0, 0, 1, 0, 0, "s2_c9");
        step(0, 0, 0, 0, 0, "s2_c10");
        drain(3);

        // Overflow: W=10, triggers in cycles 0..4.
        width = 8'd10; gap = 8'd1;
        n_rise = 0;
        step(1, 0, 0, 0, 0, "s3_c0");
        step(1, 1, 1, 0, 0, "s3_c1");
        step(1, 1, 1, 1, 0, "s3_c2");
        step(1, 1, 1, 2, 0, "s3_c3");
        step(1, 1, 1, 3, 0, "s3_c4");
        step(0, 1, 1, 3, 1, "s3_c5");
        step(0, 1, 1, 3, 0, "s3_c6");
        drain(50);
        check("s3_pulse_count", n_rise, 4);

        // W=0 G=0, trigger held for four cycles.
        width = 8'd0; gap = 8'd0;
        step(1, 0, 0, 0, 0, "s4_c0");
        step(1, 1, 1, 0, 0, "s4_c1");
        step(1, 0, 1, 1, 0, "s4_c2");
        step(1, 1, 1, 1, 0, "s4_c3");
        step(0, 0, 1, 2, 0, "s4_c4");
        step(0, 1, 1, 1, 0, "s4_c5");
        step(0, 0, 1, 1, 0, "s4_c6");
        step(0, 1, 1, 0, 0, "s4_c7");
        step(0, 0, 1, 0, 0, "s4_c8");
        step(0, 0, 0, 0, 0, "s4_c9");
        drain(3);

        // Asynchronous reset during a W=5 pulse with two queued.
        width = 8'd5; gap = 8'd2;
        step(1, 0, 0, 0, 0, "s5_c0");
        step(1, 1, 1, 0, 0, "s5_c1");
        step(1, 1, 1, 1, 0, "s5_c2");
        step(0, 1, 1, 2, 0, "s5_c3");
        #2 rst = 1'b1;
        #1;
        check("s5_async_pulse_hi", int'(hi_pulse), 0);
        check("s5_async_pulse_lo", int'(lo_pulse), 1);
        check("s5_async_pend",     int'(hi_pend),  0);
        check("s5_async_busy",     int'(hi_busy),  0);
        @(negedge clk);
        rst = 1'b0;
        prev_hi = hi_pulse;
        prev_lo = lo_pulse;
        n_rise = 0; n_act = 0;
        tick(1'b1);
        drain(12);
        check("s5_after_rise", n_rise, 1);
        check("s5_after_len",  n_act,  5);

        // Active-low polarity: W=4 G=3, three triggers.
        width = 8'd4; gap = 8'd3;
        n_fall = 0;
        check("s6_idle_lo", int'(lo_pulse), 1);
        tick(1'b1); tick(1'b1); tick(1'b1);
        drain(30);
        check("s6_fall_count", n_fall, 3);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0);
            width = c_WB'($urandom_range(0, 4));
            gap   = c_WB'($urandom_range(0, 4));
        end
        drain(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
